alu_result_checker: RTL and testbench

- Downstream stage of the reversible ALU.
- Captures each ALU result with its combinational CRC-32 tag and independently recomputes the CRC with a one-iteration-per-cycle serial engine.
- Compares the two values and emits the result with a pass/fail flag over a valid/ready handshake.
- Keeps a saturating error count for the error-detection path.

---
 rtl/alu_check_pkg.sv | 30 +++
 rtl/crc32_serial_engine.sv | 40 ++++
 rtl/alu_result_checker.sv | 122 ++++++++++++
 tb/tb_alu_result_checker.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_check_pkg.sv
// Shared constants, FSM state type and the single-iteration CRC step
// used by the ALU result checker.
package alu_check_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned CNT_W  = 6;

    localparam logic [DATA_W-1:0] CRC_POLY = 32'hEDB88320;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_MUL = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One left-shifting iteration; the polynomial is folded in when the MSB falls out.
    function automatic logic [DATA_W-1:0] crc_step(input logic [DATA_W-1:0] c,
                                                   input logic [DATA_W-1:0] poly);
        logic [DATA_W-1:0] shifted;
        shifted  = {c[DATA_W-2:0], 1'b0};
        crc_step = c[DATA_W-1] ? (shifted ^ poly) : shifted;
    endfunction

endpackage

// File: rtl/crc32_serial_engine.sv
// Serial CRC engine: one crc_step per cycle while step is high, with an
// iteration counter that flags the final iteration.
module crc32_serial_engine
    import alu_check_pkg::*;
#(
    parameter logic [DATA_W-1:0] POLY  = CRC_POLY,
    parameter int unsigned       ITERS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] crc_next_c,
    output logic              last_c
);

    logic [DATA_W-1:0] shift_reg;
    logic [CNT_W-1:0]  iter_cnt;

    assign crc_next_c = crc_step(shift_reg, POLY);
    assign last_c     = (iter_cnt == CNT_W'(ITERS - 1));

    // Counter parks on the last index rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            iter_cnt  <= '0;
        end else if (load) begin
            shift_reg <= load_data;
            iter_cnt  <= '0;
        end else if (step) begin
            shift_reg <= crc_next_c;
            if (!last_c) begin
                iter_cnt <= iter_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_result_checker.sv
// Captures ALU results with their CRC tag, recomputes the CRC serially and
// presents the result with a pass/fail flag and a saturating error count.
module alu_result_checker
    import alu_check_pkg::*;
#(
    parameter logic [DATA_W-1:0] POLY  = CRC_POLY,
    parameter int unsigned       ITERS = 32,
    parameter int unsigned       ERR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_crc,
    input  logic [OP_W-1:0]   in_opcode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [OP_W-1:0]   out_opcode,
    output logic              out_crc_ok,
    output logic [ERR_W-1:0]  err_count,
    input  logic              err_clr
);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] cap_crc;
    logic              eng_load;
    logic              eng_step;
    logic              eng_last_c;
    logic [DATA_W-1:0] eng_crc_next_c;
    logic              enter_done_c;
    logic              checked_c;
    logic              ok_c;

    crc32_serial_engine #(
        .POLY  (POLY),
        .ITERS (ITERS)
    ) u_engine (
        .clk        (clk),
        .rst        (rst),
        .load       (eng_load),
        .step       (eng_step),
        .load_data  (in_result),
        .crc_next_c (eng_crc_next_c),
        .last_c     (eng_last_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and engine control.
    always_comb begin
        state_next   = state;
        eng_load     = 1'b0;
        eng_step     = 1'b0;
        enter_done_c = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    eng_load   = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                eng_step = 1'b1;
                if (eng_last_c) begin
                    enter_done_c = 1'b1;
                    state_next   = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Non-arithmetic opcodes carry no meaningful tag and always pass.
    assign checked_c = (out_opcode == OP_ADD) || (out_opcode == OP_SUB) ||
                       (out_opcode == OP_MUL) || (out_opcode == OP_DIV);
    assign ok_c      = !checked_c || (eng_crc_next_c == cap_crc);

    // Capture, handshake flags and error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_opcode <= '0;
            out_crc_ok <= 1'b0;
            cap_crc    <= '0;
            err_count  <= '0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            if (eng_load) begin
                out_result <= in_result;
                out_opcode <= in_opcode;
                cap_crc    <= in_crc;
            end
            if (enter_done_c) begin
                out_crc_ok <= ok_c;
            end
            if (err_clr) begin
                err_count <= '0;
            end else if (enter_done_c && !ok_c && (err_count != {ERR_W{1'b1}})) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed and randomized checks of alu_result_checker; a second instance
// with a 2-bit error counter exercises saturation.
module tb_alu_result_checker;
    import alu_check_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        err_clr;
    logic [31:0] in_result;
    logic [31:0] in_crc;
    logic [3:0]  in_opcode;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_result;
    logic [3:0]  out_opcode;
    logic        out_crc_ok;
    logic [15:0] err_count;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_result;
    logic [3:0]  s_out_opcode;
    logic        s_out_crc_ok;
    logic [1:0]  s_err_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_result_checker dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_crc     (in_crc),
        .in_opcode  (in_opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_opcode (out_opcode),
        .out_crc_ok (out_crc_ok),
        .err_count  (err_count),
        .err_clr    (err_clr)
    );

    alu_result_checker #(.ERR_W(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (s_in_ready),
        .in_result  (in_result),
        .in_crc     (in_crc),
        .in_opcode  (in_opcode),
        .out_valid  (s_out_valid),
        .out_ready  (out_ready),
        .out_result (s_out_result),
        .out_opcode (s_out_opcode),
        .out_crc_ok (s_out_crc_ok),
        .err_count  (s_err_count),
        .err_clr    (1'b0)
    );

    function automatic logic [31:0] golden_crc(input logic [31:0] d);
        logic [31:0] c;
        c = d;
        for (int i = 0; i < 32; i++) begin
            c = c[31] ? ((c << 1) ^ 32'hEDB88320) : (c << 1);
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word and return just after the accepting edge.
    task automatic send(input logic [31:0] r, input logic [31:0] c, input logic [3:0] o);
        in_result = r;
        in_crc    = c;
        in_opcode = o;
        in_valid  = 1'b1;
        for (int i = 0; i < 100 && !in_ready; i++) step();
        chk("accept_ready", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        for (int i = 0; i < 100 && !out_valid; i++) step();
        chk("out_valid_wait", 64'(out_valid), 64'(1));
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hs_out_valid", 64'(out_valid), 64'(0));
        chk("hs_in_ready", 64'(in_ready), 64'(1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] c;
        logic [3:0]  o;
        logic        corrupt;
        logic        exp_ok;
        int          exp_err;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        in_result = '0; in_crc = '0; in_opcode = '0;

        // Reset state
        step();
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_result", 64'(out_result), 64'(0));
        chk("rst_out_opcode", 64'(out_opcode), 64'(0));
        chk("rst_out_crc_ok", 64'(out_crc_ok), 64'(0));
        chk("rst_err_count", 64'(err_count), 64'(0));
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));

        // Zero word: latency and pass
        send(32'h0, 32'h0, 4'd0);
        chk("t1_in_ready_low", 64'(in_ready), 64'(0));
        repeat (31) step();
        chk("t1_not_yet_valid", 64'(out_valid), 64'(0));
        step();
        chk("t1_valid_at_33", 64'(out_valid), 64'(1));
        chk("t1_crc_ok", 64'(out_crc_ok), 64'(1));
        chk("t1_result", 64'(out_result), 64'(0));
        chk("t1_err", 64'(err_count), 64'(0));
        handshake();

        // result=1 -> CRC equals POLY
        send(32'h1, 32'hEDB88320, 4'd2);
        wait_out();
        chk("t2_crc_ok", 64'(out_crc_ok), 64'(1));
        chk("t2_result", 64'(out_result), 64'(1));
        chk("t2_opcode", 64'(out_opcode), 64'(2));
        handshake();
        send(32'h1, 32'h0, 4'd2);
        wait_out();
        chk("t2b_crc_ok", 64'(out_crc_ok), 64'(0));
        chk("t2b_err", 64'(err_count), 64'(1));
        chk("t2b_sat_err", 64'(s_err_count), 64'(1));
        handshake();

        // Back-pressure: DONE holds with in_valid toggling
        send(32'hCAFE0001, golden_crc(32'hCAFE0001), 4'd1);
        wait_out();
        for (int i = 0; i < 10; i++) begin
            in_valid  = i[0];
            in_result = 32'h1111_0000 + 32'(i);
            in_opcode = 4'd3;
            step();
            chk("bp_valid", 64'(out_valid), 64'(1));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_result", 64'(out_result), 64'(32'hCAFE0001));
            chk("bp_opcode", 64'(out_opcode), 64'(1));
            chk("bp_crc_ok", 64'(out_crc_ok), 64'(1));
        end
        in_valid = 1'b0;
        handshake();
        step();
        chk("bp_no_stray_capture", 64'(out_valid), 64'(0));

        // Clear, then three bad words
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_err", 64'(err_count), 64'(0));
        for (int k = 0; k < 3; k++) begin
            r = 32'(k + 5);
            send(r, golden_crc(r) ^ 32'h1, (k == 1) ? 4'd3 : 4'd0);
            wait_out();
            chk("bad_crc_ok", 64'(out_crc_ok), 64'(0));
            handshake();
        end
        chk("three_bad_err", 64'(err_count), 64'(3));
        chk("sat_err_three", 64'(s_err_count), 64'(3));

        // err_clr coincident with a mismatch; saturated instance stays pinned
        send(32'h9, golden_crc(32'h9) ^ 32'h80, 4'd1);
        repeat (31) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("coinc_valid", 64'(out_valid), 64'(1));
        chk("coinc_crc_ok", 64'(out_crc_ok), 64'(0));
        chk("coinc_err", 64'(err_count), 64'(0));
        chk("sat_err_hold", 64'(s_err_count), 64'(3));
        handshake();

        // Unchecked opcode with wrong CRC
        send(32'h1234, 32'h0, 4'hF);
        wait_out();
        chk("opf_crc_ok", 64'(out_crc_ok), 64'(1));
        chk("opf_opcode", 64'(out_opcode), 64'(15));
        chk("opf_err", 64'(err_count), 64'(0));
        handshake();

        // Reset mid-SHIFT
        send(32'h2, 32'h0, 4'd0);
        wait_out();
        chk("pre_rst_err", 64'(err_count), 64'(1));
        handshake();
        send(32'h55, golden_crc(32'h55), 4'd0);
        repeat (15) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_state", 64'(dut.state), 64'(IDLE));
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_err", 64'(err_count), 64'(0));
        chk("abort_in_ready", 64'(in_ready), 64'(0));
        chk("abort_result", 64'(out_result), 64'(0));
        step();
        chk("abort_in_ready_after", 64'(in_ready), 64'(1));
        send(32'hDEADBEEF, golden_crc(32'hDEADBEEF), 4'd0);
        wait_out();
        chk("post_abort_ok", 64'(out_crc_ok), 64'(1));
        chk("post_abort_result", 64'(out_result), 64'(32'hDEADBEEF));
        handshake();

        // Random run against the golden model
        exp_err = 0;
        for (int n = 0; n < 1000; n++) begin
            r       = $urandom;
            o       = 4'($urandom_range(0, 15));
            corrupt = ($urandom_range(0, 9) == 0);
            c       = golden_crc(r) ^ (corrupt ? (32'h1 << $urandom_range(0, 31)) : 32'h0);
            exp_ok  = (o > 4'd3) || !corrupt;
            if (!exp_ok) exp_err++;
            send(r, c, o);
            wait_out();
            chk("rnd_crc_ok", 64'(out_crc_ok), 64'(exp_ok));
            chk("rnd_result", 64'(out_result), 64'(r));
            chk("rnd_opcode", 64'(out_opcode), 64'(o));
            chk("rnd_err", 64'(err_count), 64'(exp_err));
            handshake();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
